// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests and
// buffers responses in a DEPTH-entry queue that feeds decode. Redirects flush it.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_addr,
    input  logic              jump_valid,
    input  logic [XLEN-1:0]   jump_addr,
    input  logic              stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [INST_W-1:0] id_inst,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_pc4
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_W = DEPTH[CW:0];

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [AW-1:0]     q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [AW-1:0]     a_rd_q, a_rd_d, a_wr_q, a_wr_d;
    logic [CW-1:0]     q_cnt_q, q_cnt_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;

    logic [INST_W-1:0] q_inst_q [DEPTH];
    logic [XLEN-1:0]   q_pc_q   [DEPTH];
    logic [XLEN-1:0]   a_pc_q   [DEPTH];

    logic              redirect;
    logic [XLEN-1:0]   target;
    logic              req_fire;
    logic              rsp_drop;
    logic              rsp_push;
    logic              deq;
    logic [XLEN-1:0]   head_pc;

    assign redirect = jump_valid | branch_taken;
    assign target   = jump_valid ? jump_addr : branch_addr;

    // Outstanding requests reserve queue space, so a live response always has a slot.
    assign imem_req_valid = !reset && !redirect &&
                            (({1'b0, q_cnt_q} + {1'b0, out_q}) < DEPTH_W);
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_q != '0);
    assign rsp_push = imem_rsp_valid && (drop_q == '0) && !redirect;
    assign deq      = id_valid & id_ready & ~stall;

    assign id_valid = (q_cnt_q != '0);
    assign head_pc  = q_pc_q[q_rd_q];
    assign id_inst  = id_valid ? q_inst_q[q_rd_q] : '0;
    assign id_pc    = id_valid ? head_pc : '0;
    assign id_pc4   = id_valid ? head_pc + XLEN'(4) : '0;

    always_comb begin
        pc_d    = pc_q;
        q_rd_d  = q_rd_q;
        q_wr_d  = q_wr_q;
        a_rd_d  = a_rd_q;
        a_wr_d  = a_wr_q;
        q_cnt_d = q_cnt_q;
        drop_d  = drop_q;
        out_d   = out_q + CW'(req_fire) - CW'(imem_rsp_valid);

        if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            pc_d    = target;
            q_rd_d  = '0;
            q_wr_d  = '0;
            a_rd_d  = '0;
            a_wr_d  = '0;
            q_cnt_d = '0;
            drop_d  = out_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d   = pc_q + XLEN'(4);
                a_wr_d = a_wr_q + AW'(1);
            end
            if (rsp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_push) begin
                q_wr_d = q_wr_q + AW'(1);
                a_rd_d = a_rd_q + AW'(1);
            end
            if (deq) begin
                q_rd_d = q_rd_q + AW'(1);
            end
            q_cnt_d = q_cnt_q + CW'(rsp_push) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            q_rd_q  <= '0;
            q_wr_q  <= '0;
            a_rd_q  <= '0;
            a_wr_q  <= '0;
            q_cnt_q <= '0;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            q_rd_q  <= q_rd_d;
            q_wr_q  <= q_wr_d;
            a_rd_q  <= a_rd_d;
            a_wr_q  <= a_wr_d;
            q_cnt_q <= q_cnt_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            a_pc_q[a_wr_q] <= pc_q;
        end
        if (rsp_push) begin
            q_inst_q[q_wr_q] <= imem_rsp_data;
            q_pc_q[q_wr_q]   <= a_pc_q[a_rd_q];
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (drop_q == '0) && ({1'b0, q_cnt_q} == DEPTH_W)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a queue-based reference model of the fetch
// path plus an in-order imem model with random latency; a second instance checks PC wrap.
module tb_if_fetch_queue;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, branch_taken, jump_valid, stall;
    logic [XLEN-1:0]   branch_addr, jump_addr, imem_addr, id_pc, id_pc4;
    logic              imem_req_valid, imem_req_ready, imem_rsp_valid, id_valid, id_ready;
    logic [INST_W-1:0] imem_rsp_data, id_inst;

    logic              reset_1, branch_taken_1, jump_valid_1, stall_1;
    logic [XLEN-1:0]   branch_addr_1, jump_addr_1, imem_addr_1, id_pc_1, id_pc4_1;
    logic              imem_req_valid_1, imem_req_ready_1, imem_rsp_valid_1, id_valid_1, id_ready_1;
    logic [INST_W-1:0] imem_rsp_data_1, id_inst_1;

    if_fetch_queue #(.XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .branch_addr(branch_addr),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    if_fetch_queue #(.XLEN(XLEN), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset_1), .branch_taken(branch_taken_1), .branch_addr(branch_addr_1),
        .jump_valid(jump_valid_1), .jump_addr(jump_addr_1), .stall(stall_1),
        .imem_req_valid(imem_req_valid_1), .imem_req_ready(imem_req_ready_1), .imem_addr(imem_addr_1),
        .imem_rsp_valid(imem_rsp_valid_1), .imem_rsp_data(imem_rsp_data_1),
        .id_valid(id_valid_1), .id_ready(id_ready_1), .id_inst(id_inst_1), .id_pc(id_pc_1), .id_pc4(id_pc4_1)
    );

    typedef struct {
        logic [31:0] addr;
        logic        stale;
        int          rdy;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    req_t        infl[$];
    ent_t        fq[$];
    logic [31:0] m_pc;
    int          lat_max;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
        check_val({tag, "_id_valid"},  {31'b0, id_valid},       32'h0);
        check_val({tag, "_id_inst"},   id_inst,                 32'h0);
        check_val({tag, "_id_pc"},     id_pc,                   32'h0);
        check_val({tag, "_id_pc4"},    id_pc4,                  32'h0);
    endtask

    function automatic logic [31:0] rand_target();
        if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0;
        return $urandom & 32'h0000_FFFC;
    endfunction

    task automatic drive_inputs(input int c);
        branch_addr  = rand_target();
        jump_addr    = rand_target();
        branch_taken = 1'b0;
        jump_valid   = 1'b0;
        stall        = 1'b0;
        imem_req_ready = 1'b1;
        id_ready     = 1'b1;
        lat_max      = 3;
        if (c < 40) begin
            lat_max = 1;
        end else if (c < 60) begin
            id_ready = 1'b0;
        end else if (c >= 100 && c < 106) begin
            stall = 1'b1;
        end else if (c == 106) begin
            stall        = 1'b1;
            branch_taken = 1'b1;
            branch_addr  = 32'h100;
        end else if (c == 120) begin
            jump_valid   = 1'b1;
            jump_addr    = 32'h200;
            branch_taken = 1'b1;
            branch_addr  = 32'h300;
        end else if (c >= 60) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 9) < 7);
            stall          = ($urandom_range(0, 4) == 0);
            branch_taken   = ($urandom_range(0, 99) < 8);
            jump_valid     = ($urandom_range(0, 99) < 6);
        end
        if (infl.size() > 0 && infl[0].rdy <= c) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = infl[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        imem_rsp_valid = 1'b0;
        branch_taken   = 1'b0;
        jump_valid     = 1'b0;
        #1 check_zero_outputs("midrst");
        infl.delete();
        fq.delete();
        m_pc = 32'h0;
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    initial begin
        logic        redir, ev, fire, deq, rsp;
        logic [31:0] tgt;
        req_t        r;
        int          rdy;
        logic        fired_prev;
        logic [31:0] addr_prev;
        logic [31:0] exp_addr_1 [4];

        reset = 1'b1; branch_taken = 1'b0; jump_valid = 1'b0; stall = 1'b0;
        branch_addr = '0; jump_addr = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
        imem_rsp_data = '0; id_ready = 1'b0;
        reset_1 = 1'b1; branch_taken_1 = 1'b0; jump_valid_1 = 1'b0; stall_1 = 1'b0;
        branch_addr_1 = '0; jump_addr_1 = '0; imem_req_ready_1 = 1'b1; imem_rsp_valid_1 = 1'b0;
        imem_rsp_data_1 = '0; id_ready_1 = 1'b1;
        lat_max = 1;
        m_pc = 32'h0;

        #12 check_zero_outputs("reset");
        @(posedge clk);
        #2 reset = 1'b0;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cyc = c;
            if (c == 150 || c == 300) begin
                mid_reset();
                continue;
            end
            drive_inputs(c);
            #1;
            redir = jump_valid || branch_taken;
            tgt   = jump_valid ? jump_addr : branch_addr;
            ev    = !redir && (fq.size() + infl.size() < DEPTH);
            check_val("req_valid", {31'b0, imem_req_valid}, {31'b0, ev});
            check_val("imem_addr", imem_addr, m_pc);
            check_val("id_valid", {31'b0, id_valid}, {31'b0, fq.size() > 0});
            if (fq.size() > 0) begin
                check_val("id_inst", id_inst, fq[0].inst);
                check_val("id_pc",   id_pc,   fq[0].pc);
                check_val("id_pc4",  id_pc4,  fq[0].pc + 32'd4);
            end

            fire = ev && imem_req_ready;
            deq  = (fq.size() > 0) && id_ready && !stall;
            rsp  = imem_rsp_valid;
            if (rsp) r = infl.pop_front();
            if (redir) begin
                fq.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                m_pc = tgt;
            end else begin
                if (deq) void'(fq.pop_front());
                if (rsp && !r.stale) fq.push_back('{inst: r.data, pc: r.addr});
                if (fire) begin
                    rdy = c + $urandom_range(1, lat_max);
                    if (infl.size() > 0 && infl[$].rdy >= rdy) rdy = infl[$].rdy + 1;
                    infl.push_back('{addr: m_pc, stale: 1'b0, rdy: rdy, data: $urandom});
                    m_pc = m_pc + 32'd4;
                end
            end
        end

        // Wrap-around instance: 1-cycle imem, decode always ready.
        exp_addr_1[0] = 32'hFFFF_FFF8;
        exp_addr_1[1] = 32'hFFFF_FFFC;
        exp_addr_1[2] = 32'h0000_0000;
        exp_addr_1[3] = 32'h0000_0004;
        @(posedge clk);
        #2 reset_1 = 1'b0;
        fired_prev = 1'b0;
        addr_prev  = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cyc = 1000 + k;
            imem_rsp_valid_1 = fired_prev;
            imem_rsp_data_1  = addr_prev ^ 32'h5A5A_0000;
            #1;
            check_val("wrap_req_valid", {31'b0, imem_req_valid_1}, 32'h1);
            check_val("wrap_addr", imem_addr_1, exp_addr_1[k]);
            if (k >= 2) begin
                check_val("wrap_id_valid", {31'b0, id_valid_1}, 32'h1);
                check_val("wrap_id_pc",   id_pc_1,   exp_addr_1[k-2]);
                check_val("wrap_id_pc4",  id_pc4_1,  exp_addr_1[k-1]);
                check_val("wrap_id_inst", id_inst_1, exp_addr_1[k-2] ^ 32'h5A5A_0000);
            end
            fired_prev = imem_req_valid_1 && imem_req_ready_1;
            addr_prev  = imem_addr_1;
        end
        #2 reset_1 = 1'b1;
        imem_rsp_valid_1 = 1'b0;
        #1;
        check_val("wrap_rst_req_valid", {31'b0, imem_req_valid_1}, 32'h0);
        check_val("wrap_rst_id_valid",  {31'b0, id_valid_1},       32'h0);
        check_val("wrap_rst_id_pc",     id_pc_1,                   32'h0);
        check_val("wrap_rst_id_pc4",    id_pc4_1,                  32'h0);
        @(posedge clk);
        #2 reset_1 = 1'b0;
        @(negedge clk);
        #1;
        check_val("wrap_restart_valid", {31'b0, imem_req_valid_1}, 32'h1);
        check_val("wrap_restart_addr",  imem_addr_1,               32'hFFFF_FFF8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch stage. It owns the PC register and issues in-order requests to instruction memory through a valid/ready handshake. Fetched instructions are buffered in a DEPTH-entry queue, and decode consumes them through a valid/ready handshake. Branch and jump redirects flush the queue and discard stale in-flight responses. The block sits between the imem port and the IF/ID boundary.

Parameters:
XLEN, 32, PC and address width
INST_W, 32, instruction width
DEPTH, 4, fetch-queue entries and maximum outstanding requests (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
branch_taken  in  1  branch redirect request from EX
branch_addr  in  XLEN  branch target
jump_valid  in  1  jump redirect request (jal/jalr)
jump_addr  in  XLEN  jump target
stall  in  1  hazard stall from ID; blocks dequeue
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_addr  out  XLEN  fetch address
imem_rsp_valid  in  1  response valid (in order, latency >=1)
imem_rsp_data  in  INST_W  fetched instruction
id_valid  out  1  queue head valid
id_ready  in  1  decode can accept
id_inst  out  INST_W  head instruction
id_pc  out  XLEN  head PC
id_pc4  out  XLEN  head PC+4

Behaviour:
- Reset (async, active-high): fetch PC=RESET_PC; queue empty; outstanding=0; drop_cnt=0; imem_req_valid=0; id_valid=0; id_inst=0; id_pc=0; id_pc4=0. First request may assert in the first cycle after reset deasserts.
- Request: imem_req_valid = !reset && (count + outstanding < DEPTH) && !redirect. imem_addr = fetch PC.
- Request handshake: fires when valid&&ready. On fire, PC<=PC+4 (mod 2^XLEN) and outstanding++.
- Response: each rsp_valid decrements outstanding.
  - If drop_cnt>0: response discarded, drop_cnt--.
  - Else: pushed as {inst, pc}. The pc comes from an internal DEPTH-entry address FIFO recorded at request fire.
  - Overflow is impossible by construction. A response arriving while the queue is full and not stale is an assertion error.
- Dequeue: fires when id_valid && id_ready && !stall.
  - Push and pop in the same cycle keep count unchanged; the head updates from registered storage.
  - id_* are driven from the queue head register (no combinational path from imem_rsp).
- Redirect = jump_valid || branch_taken. Target = jump_addr if jump_valid, else branch_addr (jump wins on simultaneous assertion).
- Redirect cycle:
  - imem_req_valid forced 0; queue and address FIFO cleared.
  - PC<=target.
  - drop_cnt <= outstanding minus any response consumed that cycle, i.e. all in-flight responses are dropped.
  - A dequeue in the same cycle is still honoured (decode already took the head).
  - Redirect overrides stall.
- Stall: only blocks dequeue; fetch continues until the queue is full.
- id_pc4 = id_pc+4, wrapping to 0 at 2^XLEN-4.
- Reset mid-operation clears all state immediately. Later responses for pre-reset requests are out of scope; imem is reset on the same signal.

Test Plan:
- Reset release, imem ready always, 1-cycle latency, id_ready=1 -> id_pc sequence 0,4,8,12…, id_pc4=id_pc+4, first id_valid 2 cycles after the first request fire.
- id_ready=0 with DEPTH=4 -> exactly 4 requests fire, then imem_req_valid=0. Release id_ready -> 4 entries drain in order, fetch resumes at 0x10.
- branch_taken with branch_addr=0x100 while 3 responses are outstanding -> those 3 dropped, queue empty, next imem_addr=0x100, next id_pc=0x100.
- jump_valid (jump_addr=0x200) and branch_taken (0x300) asserted in the same cycle -> next imem_addr=0x200.
- stall=1 with id_ready=1 for 5 cycles -> id_pc held and no dequeue. Branch redirect during stall -> flush occurs and id_valid drops the next cycle.
- RESET_PC=0xFFFFFFF8 -> fetch addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x0. id_pc4 for 0xFFFFFFFC = 0x0. Async reset pulse mid-fetch -> outputs zero immediately, restart at RESET_PC.
